uart_core: RTL

Full-duplex 8N1 UART engine that sits directly upstream of the four-way UART channel selector. Its serial output `tx` drives the selector's `tx2` input, and its serial input `rx` is fed from the selector's `rx2` output. Host logic exchanges bytes over a valid/ready transmit handshake and a single-cycle receive strobe. Channel selection (s0/s1) stays outside this block, so `uart_core` is unaware which downstream UART is connected.

---
 rtl/uart_core_if.sv | 22 ++
 rtl/uart_core.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_core_if.sv
// Byte handshake and serial lines between host logic and uart_core.
// The slave modport is the core side; the master modport is host plus line side.
interface uart_core_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;

   modport master (
      output tx_data, tx_valid, rx,
      input  tx_ready, tx, rx_data, rx_valid, rx_frame_err
   );

   modport slave (
      input  tx_data, tx_valid, rx,
      output tx_ready, tx, rx_data, rx_valid, rx_frame_err
   );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART engine with 16x oversampling.
// TX and RX run independently; all outputs are registered.
module uart_core #(
   parameter int DIV = 27
) (
   input  logic       clk,
   input  logic       reset,
   uart_core_if.slave bus
);
   localparam int BIT_CYC = 16 * DIV;
   localparam int CW      = $clog2(BIT_CYC);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(8 * DIV - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   tx_state_t     tx_state_r;
   logic [CW-1:0] tx_cnt_r;
   logic [2:0]    tx_idx_r;
   logic [7:0]    tx_shift_r;
   logic          tx_r;
   logic          tx_ready_r;

   rx_state_t     rx_state_r;
   logic [CW-1:0] rx_cnt_r;
   logic [2:0]    rx_idx_r;
   logic [7:0]    rx_shift_r;
   logic [7:0]    rx_data_r;
   logic          rx_valid_r;
   logic          rx_frame_err_r;
   logic          rx_meta_r;
   logic          rx_s;

   assign bus.tx           = tx_r;
   assign bus.tx_ready     = tx_ready_r;
   assign bus.rx_data      = rx_data_r;
   assign bus.rx_valid     = rx_valid_r;
   assign bus.rx_frame_err = rx_frame_err_r;

   // Transmit FSM; tx is driven from the state held during the previous cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= '0;
         tx_idx_r   <= 3'd0;
         tx_shift_r <= 8'h00;
         tx_r       <= 1'b1;
         tx_ready_r <= 1'b1;
      end else begin
         case (tx_state_r)
            TX_IDLE: begin
               tx_r <= 1'b1;
               if (bus.tx_valid && tx_ready_r) begin
                  tx_shift_r <= bus.tx_data;
                  tx_cnt_r   <= '0;
                  tx_ready_r <= 1'b0;
                  tx_state_r <= TX_START;
               end
            end
            TX_START: begin
               tx_r <= 1'b0;
               if (tx_cnt_r == BIT_LAST) begin
                  tx_cnt_r   <= '0;
                  tx_idx_r   <= 3'd0;
                  tx_state_r <= TX_DATA;
               end else begin
                  tx_cnt_r <= tx_cnt_r + CNT_ONE;
               end
            end
            TX_DATA: begin
               tx_r <= tx_shift_r[tx_idx_r];
               if (tx_cnt_r == BIT_LAST) begin
                  tx_cnt_r <= '0;
                  if (tx_idx_r == 3'd7) begin
                     tx_state_r <= TX_STOP;
                  end else begin
                     tx_idx_r <= tx_idx_r + 3'd1;
                  end
               end else begin
                  tx_cnt_r <= tx_cnt_r + CNT_ONE;
               end
            end
            TX_STOP: begin
               tx_r <= 1'b1;
               if (tx_cnt_r == BIT_LAST) begin
                  tx_cnt_r   <= '0;
                  tx_ready_r <= 1'b1;
                  tx_state_r <= TX_IDLE;
               end else begin
                  tx_cnt_r <= tx_cnt_r + CNT_ONE;
               end
            end
            default: begin
               tx_r       <= 1'b1;
               tx_cnt_r   <= '0;
               tx_ready_r <= 1'b1;
               tx_state_r <= TX_IDLE;
            end
         endcase
      end
   end

   // Two-flop synchronizer for the asynchronous serial input; idles high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_r <= 1'b1;
         rx_s      <= 1'b1;
      end else begin
         rx_meta_r <= bus.rx;
         rx_s      <= rx_meta_r;
      end
   end

   // Receive FSM; strobes default low and pulse for exactly one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state_r     <= RX_IDLE;
         rx_cnt_r       <= '0;
         rx_idx_r       <= 3'd0;
         rx_shift_r     <= 8'h00;
         rx_data_r      <= 8'h00;
         rx_valid_r     <= 1'b0;
         rx_frame_err_r <= 1'b0;
      end else begin
         rx_valid_r     <= 1'b0;
         rx_frame_err_r <= 1'b0;
         case (rx_state_r)
            RX_IDLE: begin
               if (!rx_s) begin
                  rx_cnt_r   <= '0;
                  rx_state_r <= RX_START;
               end
            end
            RX_START: begin
               // Mid-start-bit resample rejects short glitches.
               if (rx_cnt_r == HALF_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_idx_r   <= 3'd0;
                  rx_state_r <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_ONE;
               end
            end
            RX_DATA: begin
               if (rx_cnt_r == BIT_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_shift_r <= {rx_s, rx_shift_r[7:1]};
                  if (rx_idx_r == 3'd7) begin
                     rx_state_r <= RX_STOP;
                  end else begin
                     rx_idx_r <= rx_idx_r + 3'd1;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_ONE;
               end
            end
            RX_STOP: begin
               if (rx_cnt_r == BIT_LAST) begin
                  rx_cnt_r <= '0;
                  if (rx_s) begin
                     rx_data_r  <= rx_shift_r;
                     rx_valid_r <= 1'b1;
                     rx_state_r <= RX_IDLE;
                  end else begin
                     rx_frame_err_r <= 1'b1;
                     rx_state_r     <= RX_WAIT_HIGH;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_ONE;
               end
            end
            RX_WAIT_HIGH: begin
               // A held-low line (break) must return high before a new frame.
               if (rx_s) begin
                  rx_state_r <= RX_IDLE;
               end
            end
            default: begin
               rx_cnt_r   <= '0;
               rx_state_r <= RX_IDLE;
            end
         endcase
      end
   end
endmodule
